// File: rtl/bus_if_ctrl_pkg.sv
// Shared types and constants for the bus master interface: FSM state encoding,
// bus request levels and the watchdog counter sizing helper.
package bus_if_ctrl_pkg;

  typedef enum logic [1:0] {
    BUS_IF_IDLE       = 2'b00,
    BUS_IF_BUSY       = 2'b01,
    BUS_IF_WAIT_STALL = 2'b10
  } bus_if_state_e;

  localparam logic BUS_REQ_ENABLE  = 1'b1;
  localparam logic BUS_REQ_DISABLE = 1'b0;

  // The counter must reach TIMEOUT-1; a disabled watchdog still gets one bit.
  function automatic int wdog_cnt_width(input int timeout);
    if (timeout < 2) begin
      return 1;
    end
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_if_ctrl_watchdog_cnt.sv
// Saturating cycle counter that flags a bus access which has been outstanding
// for TIMEOUT cycles. TIMEOUT = 0 disables the expire flag.
module bus_watchdog_cnt
  import bus_if_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = wdog_cnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over enable; the counter parks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_wdog_off
      assign o_expire = 1'b0;
    end else begin : g_wdog_on
      localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT - 1);
      assign o_expire = i_en && (r_cnt == EXPIRE_AT);
    end
  endgenerate

endmodule

// File: rtl/bus_if_ctrl.sv
// Bus master interface: converts single-cycle core memory accesses into req/ack
// bus transactions and stalls the pipeline until each one completes or aborts.
module bus_if_ctrl
  import bus_if_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  bus_if_state_e     r_state;
  bus_if_state_e     w_state_next;

  logic              r_bus_req;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_bus_we;
  logic [SEL_W-1:0]  r_bus_sel;
  logic [DATA_W-1:0] r_rd_buf;
  logic              r_bus_err;

  logic              w_ack;
  logic              w_expire;
  logic              w_take;
  logic              w_done;
  logic              w_drop;
  logic              w_timeout;
  logic              w_stallreq;
  logic [DATA_W-1:0] w_cpu_data;
  logic              w_wdog_en;
  logic              w_wdog_clear;

  // A stray acknowledge outside a request is never seen by the FSM.
  assign w_ack = bus_ack_i & r_bus_req;

  assign w_wdog_en    = (r_state == BUS_IF_BUSY);
  assign w_wdog_clear = (w_state_next != BUS_IF_BUSY);

  bus_watchdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wdog_clear),
    .i_en     (w_wdog_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_stallreq   = 1'b0;
    w_cpu_data   = '0;
    w_take       = 1'b0;
    w_done       = 1'b0;
    w_drop       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      BUS_IF_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          w_stallreq   = 1'b1;
          w_take       = 1'b1;
          w_state_next = BUS_IF_BUSY;
        end
      end
      BUS_IF_BUSY: begin
        // Priority: flush, then acknowledge, then watchdog expiry.
        if (flush_i) begin
          w_drop       = 1'b1;
          w_state_next = BUS_IF_IDLE;
        end else if (w_ack) begin
          w_done       = 1'b1;
          w_cpu_data   = r_bus_we ? '0 : bus_data_i;
          w_state_next = stall_i ? BUS_IF_WAIT_STALL : BUS_IF_IDLE;
        end else if (w_expire) begin
          w_drop       = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = BUS_IF_IDLE;
        end else begin
          w_stallreq   = 1'b1;
        end
      end
      BUS_IF_WAIT_STALL: begin
        w_cpu_data = r_rd_buf;
        if (!stall_i || flush_i) begin
          w_state_next = BUS_IF_IDLE;
        end
      end
      default: begin
        w_state_next = BUS_IF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BUS_IF_IDLE;
      r_bus_req  <= BUS_REQ_DISABLE;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_bus_we   <= 1'b0;
      r_bus_sel  <= '0;
      r_rd_buf   <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bus_err <= w_timeout;
      if (w_take) begin
        r_bus_req  <= BUS_REQ_ENABLE;
        r_bus_addr <= cpu_addr_i;
        r_bus_data <= cpu_data_i;
        r_bus_we   <= cpu_we_i;
        r_bus_sel  <= cpu_sel_i;
      end else if (w_done || w_drop) begin
        r_bus_req <= BUS_REQ_DISABLE;
        r_bus_we  <= 1'b0;
        r_bus_sel <= '0;
      end
      // Writes leave a zero behind so a stalled write never replays bus noise.
      if (w_done) begin
        r_rd_buf <= r_bus_we ? '0 : bus_data_i;
      end
    end
  end

  assign cpu_data_o = w_cpu_data;
  assign stallreq_o = w_stallreq;
  assign bus_err_o  = r_bus_err;
  assign bus_req_o  = r_bus_req;
  assign bus_addr_o = r_bus_addr;
  assign bus_data_o = r_bus_data;
  assign bus_we_o   = r_bus_we;
  assign bus_sel_o  = r_bus_sel;

endmodule

// File: tb/tb_bus_if_ctrl.sv
// Directed bench for bus_if_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, well away from the rising edge.
module tb_bus_if_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;

  int checks = 0;
  int errors = 0;
  int stall_cycles;

  bus_if_ctrl #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .SEL_W   (4),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .bus_req_o  (bus_req_o),
    .bus_addr_o (bus_addr_o),
    .bus_data_o (bus_data_o),
    .bus_we_o   (bus_we_o),
    .bus_sel_o  (bus_sel_o),
    .bus_data_i (bus_data_i),
    .bus_ack_i  (bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0;
    cpu_sel_i = '0; stall_i = 1'b0; flush_i = 1'b0; bus_data_i = '0; bus_ack_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk); #1;
    check("rst_bus_req", bus_req_o, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_bus_we", bus_we_o, 0);
    check("rst_bus_sel", bus_sel_o, 0);
    check("rst_bus_err", bus_err_o, 0);
    check("rst_stallreq", stallreq_o, 0);
    check("rst_cpu_data", cpu_data_o, 0);
    rst = 1'b0;

    // 1: read, ack three cycles after the request rises
    stall_cycles = 0;
    @(negedge clk); cpu_ce_i = 1'b1; cpu_addr_i = 32'h40; cpu_we_i = 1'b0; cpu_sel_i = 4'hF; #1;
    check("t1_idle_stallreq", stallreq_o, 1);
    check("t1_idle_cpu_data", cpu_data_o, 0);
    if (stallreq_o) stall_cycles++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t1_busy_req", bus_req_o, 1);
      check("t1_busy_addr", bus_addr_o, 32'h40);
      if (stallreq_o) stall_cycles++;
    end
    @(negedge clk); bus_ack_i = 1'b1; bus_data_i = 32'hDEADBEEF; #1;
    check("t1_ack_cpu_data", cpu_data_o, 32'hDEADBEEF);
    check("t1_ack_stallreq", stallreq_o, 0);
    if (stallreq_o) stall_cycles++;
    @(negedge clk); bus_ack_i = 1'b0; bus_data_i = '0; cpu_ce_i = 1'b0; #1;
    check("t1_after_req", bus_req_o, 0);
    check("t1_after_cpu_data", cpu_data_o, 0);
    check("t1_stall_cycles", stall_cycles, 4);

    // Stray acknowledge in IDLE is ignored
    @(negedge clk); bus_ack_i = 1'b1; bus_data_i = 32'h55AA55AA; #1;
    check("stray_ack_cpu_data", cpu_data_o, 0);
    @(negedge clk); bus_ack_i = 1'b0; bus_data_i = '0; #1;
    check("stray_ack_req", bus_req_o, 0);
    check("stray_ack_stallreq", stallreq_o, 0);

    // 2: write, bus fields stable while cpu_* changes
    @(negedge clk); cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h100;
    cpu_data_i = 32'h12345678; cpu_sel_i = 4'b0011; #1;
    check("t2_idle_stallreq", stallreq_o, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); cpu_addr_i = 32'hFFFF0000 + i; cpu_data_i = 32'h0; cpu_sel_i = 4'hF;
      cpu_we_i = 1'b0; #1;
      check("t2_busy_req", bus_req_o, 1);
      check("t2_busy_addr", bus_addr_o, 32'h100);
      check("t2_busy_data", bus_data_o, 32'h12345678);
      check("t2_busy_sel", bus_sel_o, 4'b0011);
      check("t2_busy_we", bus_we_o, 1);
      check("t2_busy_stallreq", stallreq_o, 1);
    end
    @(negedge clk); bus_ack_i = 1'b1; bus_data_i = 32'hAAAA5555; #1;
    check("t2_ack_cpu_data", cpu_data_o, 0);
    check("t2_ack_stallreq", stallreq_o, 0);
    check("t2_ack_addr", bus_addr_o, 32'h100);
    @(negedge clk); bus_ack_i = 1'b0; bus_data_i = '0; cpu_ce_i = 1'b0; #1;
    check("t2_after_we", bus_we_o, 0);
    check("t2_after_req", bus_req_o, 0);
    check("t2_after_sel", bus_sel_o, 0);

    // 3: ack while stalled elsewhere -> hold data in WAIT_STALL
    @(negedge clk); cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF; #1;
    @(negedge clk); #1;
    check("t3_busy_req", bus_req_o, 1);
    @(negedge clk); bus_ack_i = 1'b1; bus_data_i = 32'hCAFEF00D; stall_i = 1'b1; #1;
    check("t3_ack_cpu_data", cpu_data_o, 32'hCAFEF00D);
    check("t3_ack_stallreq", stallreq_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus_ack_i = 1'b0; bus_data_i = 32'h0BADBAD0; cpu_ce_i = 1'b0; #1;
      check("t3_wait_cpu_data", cpu_data_o, 32'hCAFEF00D);
      check("t3_wait_stallreq", stallreq_o, 0);
      check("t3_wait_req", bus_req_o, 0);
    end
    @(negedge clk); stall_i = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h999; #1;
    check("t3_release_cpu_data", cpu_data_o, 32'hCAFEF00D);
    check("t3_release_stallreq", stallreq_o, 0);
    @(negedge clk); cpu_ce_i = 1'b0; bus_data_i = '0; #1;
    check("t3_idle_cpu_data", cpu_data_o, 0);
    check("t3_no_new_req", bus_req_o, 0);

    // 4: flush and ack in the same BUSY cycle -> flush wins
    @(negedge clk); cpu_ce_i = 1'b1; cpu_addr_i = 32'h300; #1;
    @(negedge clk); #1;
    check("t4_busy_req", bus_req_o, 1);
    @(negedge clk); flush_i = 1'b1; bus_ack_i = 1'b1; bus_data_i = 32'h11112222; #1;
    check("t4_flush_cpu_data", cpu_data_o, 0);
    check("t4_flush_stallreq", stallreq_o, 0);
    @(negedge clk); flush_i = 1'b0; bus_ack_i = 1'b0; cpu_ce_i = 1'b0; #1;
    check("t4_after_req", bus_req_o, 0);
    check("t4_after_cpu_data", cpu_data_o, 0);
    @(negedge clk); bus_data_i = '0; #1;
    check("t4_idle_cpu_data", cpu_data_o, 0);
    check("t4_no_err", bus_err_o, 0);

    // 5: watchdog (TIMEOUT=8), slave never acknowledges
    @(negedge clk); cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; #1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); #1;
      check("t5_busy_stallreq", stallreq_o, 1);
      check("t5_busy_err", bus_err_o, 0);
    end
    @(negedge clk); bus_data_i = 32'h77777777; #1;
    check("t5_expire_stallreq", stallreq_o, 0);
    check("t5_expire_cpu_data", cpu_data_o, 0);
    check("t5_expire_err_not_yet", bus_err_o, 0);
    @(negedge clk); cpu_ce_i = 1'b0; bus_data_i = '0; #1;
    check("t5_err_pulse", bus_err_o, 1);
    check("t5_req_dropped", bus_req_o, 0);
    @(negedge clk); #1;
    check("t5_err_single", bus_err_o, 0);

    // 6: reset two cycles into BUSY, then a clean read
    @(negedge clk); cpu_ce_i = 1'b1; cpu_addr_i = 32'h500; #1;
    @(negedge clk); #1;
    check("t6_busy_req", bus_req_o, 1);
    @(negedge clk); rst = 1'b1; cpu_ce_i = 1'b0; #1;
    @(negedge clk); #1;
    check("t6_rst_req", bus_req_o, 0);
    check("t6_rst_addr", bus_addr_o, 0);
    check("t6_rst_err", bus_err_o, 0);
    check("t6_rst_stallreq", stallreq_o, 0);
    check("t6_rst_cpu_data", cpu_data_o, 0);
    rst = 1'b0;
    @(negedge clk); cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; #1;
    check("t6_new_stallreq", stallreq_o, 1);
    @(negedge clk); #1;
    check("t6_new_addr", bus_addr_o, 32'h600);
    @(negedge clk); bus_ack_i = 1'b1; bus_data_i = 32'h600D600D; #1;
    check("t6_new_cpu_data", cpu_data_o, 32'h600D600D);
    check("t6_new_stallreq_ack", stallreq_o, 0);
    @(negedge clk); bus_ack_i = 1'b0; bus_data_i = '0; cpu_ce_i = 1'b0; #1;
    check("t6_new_done_req", bus_req_o, 0);
    check("t6_new_done_err", bus_err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
